// File: rtl/bec_pkg.sv
// Shared definitions for the BEC Montgomery-ladder sequencer: state codes,
// operand slot indices and the default field width.
package bec_pkg;

    localparam int BEC_NBITS = 163;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'h0,
        ST_LOAD  = 4'h1,
        ST_REQ   = 4'h2,
        ST_WAIT  = 4'h3,
        ST_SHIFT = 4'h4,
        ST_DONE  = 4'h8
    } bec_state_t;

    localparam logic [2:0] SLOT_W1  = 3'd0;
    localparam logic [2:0] SLOT_Z1  = 3'd1;
    localparam logic [2:0] SLOT_W2  = 3'd2;
    localparam logic [2:0] SLOT_Z2  = 3'd3;
    localparam logic [2:0] SLOT_INV = 3'd4;
    localparam logic [2:0] SLOT_D   = 3'd5;

endpackage

// File: rtl/bec_opbank.sv
// Six-slot operand register file: controller write port plus the
// four-wide step write-back port from the ladder datapath.
module bec_opbank
    import bec_pkg::*;
#(
    parameter int NBITS = BEC_NBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_slot,
    input  logic [NBITS-1:0] wr_data,
    input  logic             wb_en,
    input  logic [NBITS-1:0] w1n,
    input  logic [NBITS-1:0] z1n,
    input  logic [NBITS-1:0] w2n,
    input  logic [NBITS-1:0] z2n,
    output logic [NBITS-1:0] w1,
    output logic [NBITS-1:0] z1,
    output logic [NBITS-1:0] w2,
    output logic [NBITS-1:0] z2,
    output logic [NBITS-1:0] inv_w0,
    output logic [NBITS-1:0] d
);

    // Write-back and slot writes live in disjoint FSM states, so the
    // priority order here never actually arbitrates.
    always_ff @(posedge clk) begin
        if (rst) begin
            w1     <= '0;
            z1     <= '0;
            w2     <= '0;
            z2     <= '0;
            inv_w0 <= '0;
            d      <= '0;
        end else if (wb_en) begin
            w1 <= w1n;
            z1 <= z1n;
            w2 <= w2n;
            z2 <= z2n;
        end else if (wr_en) begin
            case (wr_slot)
                SLOT_W1:  w1     <= wr_data;
                SLOT_Z1:  z1     <= wr_data;
                SLOT_W2:  w2     <= wr_data;
                SLOT_Z2:  z2     <= wr_data;
                SLOT_INV: inv_w0 <= wr_data;
                SLOT_D:   d      <= wr_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bec_ladder_seq.sv
// Ladder step sequencer: loads operands, runs NBITS datapath steps one key
// bit at a time, and exposes the final bank for readback.
module bec_ladder_seq
    import bec_pkg::*;
#(
    parameter int NBITS = BEC_NBITS
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             master_ena_proc,
    input  logic             load_data,
    input  logic [2:0]       load_status,
    input  logic             trigLoad,
    input  logic [NBITS-1:0] data_out,
    input  logic             ki,
    output logic             next_key,
    output logic             slv_done,
    output logic [3:0]       becStatus,
    output logic [NBITS-1:0] data_in,
    output logic [NBITS-1:0] op_w1,
    output logic [NBITS-1:0] op_z1,
    output logic [NBITS-1:0] op_w2,
    output logic [NBITS-1:0] op_z2,
    output logic [NBITS-1:0] op_inv,
    output logic [NBITS-1:0] op_d,
    output logic             dp_start,
    output logic             dp_ki,
    input  logic             dp_done,
    input  logic [NBITS-1:0] dp_w1n,
    input  logic [NBITS-1:0] dp_z1n,
    input  logic [NBITS-1:0] dp_w2n,
    input  logic [NBITS-1:0] dp_z2n
);

    localparam logic [7:0] LAST_STEP = 8'(NBITS - 1);

    bec_state_t state;
    logic [7:0] cnt;
    logic       trig_q;
    logic       wr_en;
    logic       wb_en;

    assign wr_en = load_data && trigLoad && !trig_q
                   && (state == ST_IDLE || state == ST_LOAD)
                   && (load_status <= SLOT_D);
    assign wb_en = (state == ST_WAIT) && dp_done;
    assign becStatus = state;

    bec_opbank #(.NBITS(NBITS)) u_bank (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .wr_en   (wr_en),
        .wr_slot (load_status),
        .wr_data (data_out),
        .wb_en   (wb_en),
        .w1n     (dp_w1n),
        .z1n     (dp_z1n),
        .w2n     (dp_w2n),
        .z2n     (dp_z2n),
        .w1      (op_w1),
        .z1      (op_z1),
        .w2      (op_w2),
        .z2      (op_z2),
        .inv_w0  (op_inv),
        .d       (op_d)
    );

    // next_key is raised on entry to SHIFT so the controller's shifted ki
    // is already settled when the following REQ latches it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            trig_q   <= 1'b0;
            dp_ki    <= 1'b0;
            dp_start <= 1'b0;
            next_key <= 1'b0;
            slv_done <= 1'b0;
        end else begin
            trig_q   <= trigLoad;
            dp_start <= 1'b0;
            next_key <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_data) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (master_ena_proc) begin
                        state <= ST_REQ;
                        cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    if (!master_ena_proc) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        dp_ki    <= ki;
                        dp_start <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dp_done && master_ena_proc) begin
                        state    <= ST_SHIFT;
                        next_key <= 1'b1;
                    end else if (!master_ena_proc) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!master_ena_proc) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == LAST_STEP) begin
                            state    <= ST_DONE;
                            slv_done <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    if (!master_ena_proc && load_data) begin
                        state    <= ST_IDLE;
                        slv_done <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_in = '0;
        if (state == ST_DONE) begin
            case (load_status)
                SLOT_W1:  data_in = op_w1;
                SLOT_Z1:  data_in = op_z1;
                SLOT_W2:  data_in = op_w2;
                SLOT_Z2:  data_in = op_z2;
                SLOT_INV: data_in = op_inv;
                SLOT_D:   data_in = op_d;
                default:  data_in = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bec_ladder_seq.sv
// Directed bench for bec_ladder_seq with a 3-cycle-latency datapath model
// that returns w1+1 and passes the other operands through.
module tb_bec_ladder_seq;

    localparam int NB = 163;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          load_data = 1'b0;
    logic [2:0]    load_status = 3'd0;
    logic          trigLoad = 1'b0;
    logic [NB-1:0] data_out = '0;
    logic          ki = 1'b1;
    logic          next_key, slv_done, dp_start, dp_ki;
    logic [3:0]    becStatus;
    logic [NB-1:0] data_in, op_w1, op_z1, op_w2, op_z2, op_inv, op_d;
    logic          dp_done = 1'b0;
    logic [NB-1:0] dp_w1n = '0, dp_z1n = '0, dp_w2n = '0, dp_z2n = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int starts  = 0;
    int keys    = 0;
    int ki_err  = 0;
    int lat     = 0;
    logic [NB-1:0] key_vec;

    bec_ladder_seq #(.NBITS(NB)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .master_ena_proc(ena),
        .load_data(load_data), .load_status(load_status), .trigLoad(trigLoad),
        .data_out(data_out), .ki(ki), .next_key(next_key), .slv_done(slv_done),
        .becStatus(becStatus), .data_in(data_in),
        .op_w1(op_w1), .op_z1(op_z1), .op_w2(op_w2), .op_z2(op_z2),
        .op_inv(op_inv), .op_d(op_d), .dp_start(dp_start), .dp_ki(dp_ki),
        .dp_done(dp_done), .dp_w1n(dp_w1n), .dp_z1n(dp_z1n),
        .dp_w2n(dp_w2n), .dp_z2n(dp_z2n)
    );

    always #5 clk = ~clk;

    // Datapath and key-controller model, evaluated away from the active edge.
    always @(negedge clk) begin
        if (dp_start) begin
            if (dp_ki !== ((keys % 2) == 0)) ki_err++;
            starts++;
            lat = 3;
        end else if (lat > 0) begin
            lat--;
        end
        dp_done = (lat == 1);
        dp_w1n  = op_w1 + 1'b1;
        dp_z1n  = op_z1;
        dp_w2n  = op_w2;
        dp_z2n  = op_z2;
        if (next_key) keys++;
        ki = key_vec[keys % NB];
    end

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_slot(input logic [2:0] s, input logic [NB-1:0] v);
        load_data = 1'b1; load_status = s; data_out = v; trigLoad = 1'b1;
        step();
        trigLoad = 1'b0;
        step();
    endtask

    initial begin
        int base_s, base_k, i;
        for (int b = 0; b < NB; b++) key_vec[b] = ((b % 2) == 0);
        ki = key_vec[0];
        step(); step(); step();
        chk("rst_status", becStatus, 0);
        chk("rst_done", slv_done, 0);
        chk("rst_start", dp_start, 0);
        chk("rst_nextkey", next_key, 0);
        chk("rst_dpki", dp_ki, 0);
        chk("rst_datain", data_in, 0);
        chk("rst_w1", op_w1, 0);
        rst = 1'b0;
        step();

        for (int s = 0; s < 6; s++) load_slot(3'(s), NB'(s + 1));
        chk("load_w1", op_w1, 1);  chk("load_z1", op_z1, 2);
        chk("load_w2", op_w2, 3);  chk("load_z2", op_z2, 4);
        chk("load_inv", op_inv, 5); chk("load_d", op_d, 6);
        chk("load_state", becStatus, 4'h1);
        load_slot(3'd6, NB'(8'h77));
        chk("slot6_w1", op_w1, 1);  chk("slot6_z1", op_z1, 2);
        chk("slot6_w2", op_w2, 3);  chk("slot6_z2", op_z2, 4);
        chk("slot6_inv", op_inv, 5); chk("slot6_d", op_d, 6);

        load_status = 3'd1; data_out = NB'(8'h55); trigLoad = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            data_out = NB'(8'h99 + c);
        end
        step();
        trigLoad = 1'b0;
        step();
        chk("trig_held_once", op_z1, NB'(8'h55));
        load_slot(3'd1, NB'(2));
        chk("trig_rewrite", op_z1, 2);

        base_s = starts; base_k = keys; ki_err = 0;
        load_status = 3'd0; ena = 1'b1; load_data = 1'b0;
        i = 0;
        while (!slv_done && i < 5000) begin step(); i++; end
        chk("run_timeout", (i < 5000), 1);
        chk("run_starts", starts - base_s, NB);
        chk("run_nextkeys", keys - base_k, NB);
        chk("run_ki", ki_err, 0);
        chk("run_status", becStatus, 4'h8);
        chk("run_datain_w1", data_in, NB'(1 + NB));
        load_status = 3'd5;
        #1 chk("run_datain_d", data_in, 6);
        load_status = 3'd6;
        #1 chk("run_datain_s6", data_in, 0);
        load_status = 3'd1;
        #1 chk("run_datain_z1", data_in, 2);
        ena = 1'b0; load_data = 1'b1;
        step();
        chk("done_exit_status", becStatus, 4'h0);
        chk("done_exit_flag", slv_done, 0);
        chk("idle_datain", data_in, 0);

        step();
        base_s = starts; base_k = keys;
        load_data = 1'b0; ena = 1'b1;
        i = 0;
        while ((keys - base_k) < 10 && i < 500) begin step(); i++; end
        chk("abort_reach", (i < 500), 1);
        ena = 1'b0;
        step();
        chk("abort_status", becStatus, 4'h0);
        chk("abort_cnt", dut.cnt, 0);
        chk("abort_w1", op_w1, NB'(1 + NB + 10));
        chk("abort_z1", op_z1, 2);
        step(); step(); step();
        chk("abort_starts", starts - base_s, 10);
        chk("abort_keys", keys - base_k, 10);

        load_data = 1'b1;
        step();
        load_data = 1'b0; ena = 1'b1;
        i = 0;
        while (becStatus != 4'h3 && i < 50) begin step(); i++; end
        chk("wait_reach", becStatus, 4'h3);
        rst = 1'b1;
        step();
        chk("wrst_status", becStatus, 0);
        chk("wrst_start", dp_start, 0);
        chk("wrst_nextkey", next_key, 0);
        chk("wrst_dpki", dp_ki, 0);
        chk("wrst_w1", op_w1, 0);
        chk("wrst_d", op_d, 0);
        chk("wrst_done", slv_done, 0);
        base_s = starts; base_k = keys;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("post_rst_starts", starts - base_s, 0);
        chk("post_rst_keys", keys - base_k, 0);
        chk("post_rst_status", becStatus, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bec_ladder_seq.md
BEC_LADDER_SEQ -- requirements
Module: bec_ladder_seq

Interface
REQ-001 SHALL use the parameter NBITS, default 163, giving the GF(2^163) operand width and the key length.
REQ-002 SHALL have these ports:
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- master_ena_proc  in  1  run request from the controller.
- load_data  in  1  write window is open.
- load_status  in  3  operand slot: 0=w1, 1=z1, 2=w2, 3=z2, 4=inv_w0, 5=d.
- trigLoad  in  1  load strobe; its rising edge qualifies the write.
- data_out  in  NBITS  operand data from the controller.
- ki  in  1  current key bit, LSB first.
- next_key  out  1  one-cycle pulse asking the controller to shift the key.
- slv_done  out  1  ladder complete.
- becStatus  out  4  state code.
- data_in  out  NBITS  result readback to the controller.
- op_w1, op_z1, op_w2, op_z2, op_inv, op_d  out  NBITS each  operand bank contents for the datapath.
- dp_start  out  1  one-cycle pulse starting one ladder step.
- dp_ki  out  1  key bit for the current step.
- dp_done  in  1  step complete; write-back is valid.
- dp_w1n, dp_z1n, dp_w2n, dp_z2n  in  NBITS each  step results.

Function
REQ-003 SHALL implement the states IDLE(0x0), LOAD(0x1), REQ(0x2), WAIT(0x3), SHIFT(0x4), DONE(0x8); becStatus SHALL equal the current state code.
REQ-004 SHALL detect trigLoad edges with a 1-cycle delayed copy, trig_q.
REQ-005 SHALL write data_out into bank[load_status] when load_data=1, trigLoad=1 and trig_q=0; this write SHALL be allowed in IDLE and LOAD only.
REQ-006 SHALL ignore writes with load_status 6 or 7.
REQ-007 SHALL move IDLE->LOAD on load_data=1.
REQ-008 SHALL move LOAD->REQ on master_ena_proc=1 and clear the step counter cnt (8 bits) in the same transition.
REQ-009 SHALL, in REQ, latch dp_ki<=ki, pulse dp_start for exactly 1 cycle, then go to WAIT.
REQ-010 SHALL, in WAIT, load dp_w1n/dp_z1n/dp_w2n/dp_z2n into w1/z1/w2/z2 on the cycle dp_done=1, then go to SHIFT; inv_w0 and d SHALL stay unchanged.
REQ-011 SHALL, in SHIFT, pulse next_key for 1 cycle and increment cnt.
REQ-012 SHALL leave SHIFT for DONE when the pre-increment cnt equals NBITS-1, and for REQ otherwise.
REQ-013 SHALL execute exactly NBITS steps.
REQ-014 SHALL place at least 2 cycles between dp_start pulses, so the controller's new ki is valid at the next REQ.
REQ-015 SHALL, in DONE, hold slv_done=1 and drive data_in = w1/z1/w2/z2/inv_w0/d for load_status 0..5, and 0 for 6..7.
REQ-016 SHALL drive data_in=0 in every state other than DONE.
REQ-017 SHALL move DONE->IDLE when master_ena_proc=0 and load_data=1, and clear slv_done on that transition.
REQ-018 SHALL abort to IDLE when master_ena_proc falls in REQ, WAIT or SHIFT, with cnt cleared, the bank retained and no next_key pulse.
REQ-019 SHALL ignore dp_done outside WAIT.
REQ-020 SHALL give dp_done priority over an abort in WAIT: the write-back completes, then the block enters IDLE.
REQ-021 SHALL drive op_* continuously from the bank.

Reset
REQ-022 SHALL, with wb_rst_i=1 at a wb_clk_i edge, force state=IDLE, cnt=0, all bank registers=0, trig_q=0, dp_ki=0, and every output=0.
REQ-023 SHALL override all other inputs with a mid-operation reset and SHALL NOT issue a dp_start or next_key pulse on the cycle reset releases.

Structure
REQ-024 SHALL take the state codes, the slot indices 0..5 and NBITS from the shared package bec_pkg.
REQ-025 SHALL instantiate one sub-module, bec_opbank: the 6xNBITS register file with the slot write port and the step write-back port.
REQ-026 SHALL keep the remaining logic (FSM, counter, pulses) at the top level.

Verification
REQ-027 SHALL cover a load: six trigLoad rising edges with load_status 0..5 and data 0x1..0x6 -> op_w1..op_d = 1..6; a seventh edge with load_status=6 leaves all slots unchanged.
REQ-028 SHALL cover a full run: a datapath model with 3-cycle dp_done latency returns w1+1 -> exactly 163 dp_start and 163 next_key pulses, then slv_done=1, becStatus=0x8, and data_in=0x1+163 with load_status=0.
REQ-029 SHALL cover key bits: ki sequence 1,0,1,... -> dp_ki matches ki at each dp_start.
REQ-030 SHALL cover an abort: master_ena_proc dropped after step 10 -> IDLE within 1 cycle, cnt=0, bank holds step-10 values.
REQ-031 SHALL cover reset during WAIT: synchronous wb_rst_i -> all outputs 0 next edge; no pulses after release.
REQ-032 SHALL cover the trigLoad edge rule: trigLoad held high for 5 cycles -> a single write.
